// File: rtl/mmu_walk_arbiter_pkg.sv
// Shared definitions for the page-table walk arbiter: FSM encodings and the
// forced-fault word returned to a walker when the bus hangs.
package mmu_walk_arbiter_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int PRESENT_BIT = 0;

  // A zero entry with the present bit explicitly clear makes the MMU raise a page fault.
  function automatic word_t fault_word();
    word_t w;
    w = '0;
    w[PRESENT_BIT] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the port that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    if (&req_i) begin
      grant_o = ~last_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/mmu_walk_arbiter.sv
// Shares one page-table fetch port between the instruction and data MMU walkers,
// holding the grant for a whole walk and forcing a fault completion on bus hang.
module mmu_walk_arbiter
  import mmu_walk_arbiter_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int CNT_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        suspend,
  input  logic        ren0,
  input  logic [31:0] addr0,
  output logic        ack0,
  output logic [31:0] data0,
  input  logic        ren1,
  input  logic [31:0] addr1,
  output logic        ack1,
  output logic [31:0] data1,
  output logic        ren,
  output logic [31:0] addr,
  input  logic        ack,
  input  logic [31:0] data,
  output logic        timeout,
  output logic        busy
);

  localparam logic [CNT_BITS-1:0] WD_LAST = CNT_BITS'(TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [CNT_BITS-1:0] wd_q, wd_d;
  logic                fire_q, fire_d;

  logic        kill;
  logic        ren_g;
  logic [31:0] addr_g;
  logic        pick_grant;
  logic        pick_valid;
  logic        ack_g;
  logic [31:0] data_g;

  assign kill   = rst | suspend;
  assign ren_g  = grant_q ? ren1 : ren0;
  assign addr_g = grant_q ? addr1 : addr0;

  rr_arb2 u_rr (
    .req_i   ({ren1, ren0}),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    fire_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (pick_valid) begin
          grant_d = pick_grant;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (fire_q) begin
          wd_d    = '0;
          state_d = S_DRAIN;
        end else if (!ren_g) begin
          wd_d    = '0;
          last_d  = grant_q;
          state_d = S_IDLE;
        end else if (ack) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          // Terminal count: the forced completion is presented on the next cycle.
          wd_d   = '0;
          fire_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!ren_g) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
      grant_d = 1'b0;
      last_d  = 1'b1;
      wd_d    = '0;
      fire_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      fire_q  <= fire_d;
    end
  end

  always_comb begin
    ren     = 1'b0;
    addr    = '0;
    ack_g   = 1'b0;
    data_g  = '0;
    timeout = 1'b0;
    if (!kill && state_q == S_BUSY) begin
      if (fire_q) begin
        ack_g   = 1'b1;
        data_g  = fault_word();
        timeout = 1'b1;
      end else begin
        ren    = ren_g;
        addr   = addr_g;
        ack_g  = ack & ren_g;
        data_g = data;
      end
    end
  end

  assign ack0  = ack_g & ~grant_q;
  assign ack1  = ack_g & grant_q;
  assign data0 = grant_q ? '0 : data_g;
  assign data1 = grant_q ? data_g : '0;
  assign busy  = (state_q == S_BUSY) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// Directed and randomized bench for mmu_walk_arbiter, checked every cycle
// against a walk-level reference model (owner, silent-cycle count, pending fault).
module tb_mmu_walk_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, suspend;
  logic        ren0, ren1, ack;
  logic [31:0] addr0, addr1, data;
  logic        ack0, ack1, ren, timeout, busy;
  logic [31:0] data0, data1, addr;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int m_owner = -1;
  bit m_drain = 0;
  int m_last  = 1;
  int m_stall = 0;
  bit m_fault = 0;

  always #5 clk = ~clk;

  mmu_walk_arbiter #(.TIMEOUT(TO), .CNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .suspend(suspend),
    .ren0(ren0), .addr0(addr0), .ack0(ack0), .data0(data0),
    .ren1(ren1), .addr1(addr1), .ack1(ack1), .data1(data1),
    .ren(ren), .addr(addr), .ack(ack), .data(data),
    .timeout(timeout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic req_of(input int p);
    return (p == 1) ? ren1 : ren0;
  endfunction

  // Compare every output against the model at the falling edge.
  task automatic settle();
    logic        e_ren, e_ack0, e_ack1, e_to, e_busy, r;
    logic [31:0] e_addr, e_d0, e_d1;
    @(negedge clk);
    e_ren = 0; e_addr = 0; e_ack0 = 0; e_ack1 = 0; e_d0 = 0; e_d1 = 0; e_to = 0;
    e_busy = (m_owner != -1);
    if (!(rst || suspend) && m_owner != -1 && !m_drain) begin
      if (m_fault) begin
        e_to = 1;
        if (m_owner == 0) e_ack0 = 1; else e_ack1 = 1;
      end else begin
        r      = req_of(m_owner);
        e_ren  = r;
        e_addr = (m_owner == 1) ? addr1 : addr0;
        if (m_owner == 0) begin e_ack0 = ack & r; e_d0 = data; end
        else              begin e_ack1 = ack & r; e_d1 = data; end
      end
    end
    chk("ren", ren, e_ren);
    chk("addr", addr, e_addr);
    chk("ack0", ack0, e_ack0);
    chk("ack1", ack1, e_ack1);
    chk("data0", data0, e_d0);
    chk("data1", data1, e_d1);
    chk("timeout", timeout, e_to);
    chk("busy", busy, e_busy);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst || suspend) begin
      m_owner = -1; m_drain = 0; m_last = 1; m_stall = 0; m_fault = 0;
    end else if (m_owner == -1) begin
      m_stall = 0;
      if (ren0 && ren1) m_owner = 1 - m_last;
      else if (ren0)    m_owner = 0;
      else if (ren1)    m_owner = 1;
    end else if (m_fault) begin
      m_fault = 0; m_drain = 1; m_stall = 0;
    end else if (m_drain) begin
      if (!req_of(m_owner)) begin
        m_last = m_owner; m_owner = -1; m_drain = 0;
      end
    end else if (!req_of(m_owner)) begin
      m_last = m_owner; m_owner = -1; m_stall = 0;
    end else if (ack) begin
      m_stall = 0;
    end else begin
      m_stall++;
      if (m_stall == TO) begin
        m_fault = 1; m_stall = 0;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  initial begin
    rst = 1; suspend = 0; ren0 = 0; ren1 = 0; ack = 0;
    addr0 = 0; addr1 = 0; data = 0;
    advance();
    advance();
    tick();
    rst = 0;
    tick();

    // 1: single request, pass-through of ack/data
    ren0 = 1; addr0 = 32'h0000_1004;
    settle(); chk("t1_latency_ren", ren, 0); advance();
    ack = 1; data = 32'h0000_2003;
    settle();
    chk("t1_ren", ren, 1); chk("t1_addr", addr, 32'h0000_1004);
    chk("t1_ack0", ack0, 1); chk("t1_data0", data0, 32'h0000_2003); chk("t1_ack1", ack1, 0);
    advance();
    ack = 0; ren0 = 0; tick(); tick();

    // 2: simultaneous requests after reset, port 0 first, then alternation
    rst = 1; tick(); rst = 0;
    ren0 = 1; ren1 = 1; addr0 = 32'hA000_0000; addr1 = 32'hB000_0000;
    tick();
    settle(); chk("t2_first_p0", addr, 32'hA000_0000); advance();
    ack = 1; tick(); ack = 0;
    ren0 = 0; tick();
    tick();
    settle(); chk("t2_then_p1", addr, 32'hB000_0000); chk("t2_p1_ren", ren, 1); advance();
    ren0 = 1; ren1 = 0; tick();
    tick();
    settle(); chk("t2_back_p0", addr, 32'hA000_0000); advance();
    ren0 = 0; tick(); tick();

    // 3: two-fetch walk on port 1, port 0 waits until ren1 falls
    ren1 = 1; addr1 = 32'h0000_3000; tick();
    ack = 1; data = 32'h0000_4001; tick();
    ack = 0; addr1 = 32'h0000_4008; ren0 = 1; addr0 = 32'h0000_5000; tick();
    settle(); chk("t3_hold_addr", addr, 32'h0000_4008); chk("t3_hold_ack0", ack0, 0); advance();
    ack = 1; data = 32'h0000_6003;
    settle(); chk("t3_pte_ack1", ack1, 1); chk("t3_pte_data1", data1, 32'h0000_6003); advance();
    ack = 0; ren1 = 0; tick();
    tick();
    settle(); chk("t3_p0_granted", addr, 32'h0000_5000); advance();
    ren0 = 0; tick(); tick();

    // 4: watchdog with TIMEOUT=4
    ren0 = 1; addr0 = 32'h0000_7000; data = 32'hFFFF_FFFF; tick();
    for (int i = 0; i < TO; i++) begin
      settle(); chk("t4_no_early_to", timeout, 0); advance();
    end
    settle();
    chk("t4_ack0", ack0, 1); chk("t4_data0", data0, 32'h0); chk("t4_timeout", timeout, 1);
    chk("t4_ren_drop", ren, 0);
    advance();
    ack = 1;
    settle(); chk("t4_drain_busy", busy, 1); chk("t4_drain_ack0", ack0, 0); advance();
    ack = 0; ren0 = 0; tick();
    settle(); chk("t4_idle", busy, 0); advance();

    // 5: suspend mid-walk with a coincident ack
    ren1 = 1; addr1 = 32'h0000_8000; tick(); tick();
    suspend = 1; ack = 1;
    settle(); chk("t5_ren", ren, 0); chk("t5_ack0", ack0, 0); chk("t5_ack1", ack1, 0); advance();
    suspend = 0; ack = 0; ren1 = 0;
    settle(); chk("t5_idle", busy, 0); advance();

    // 6: reset during a walk, then port 0 wins first
    ren0 = 1; addr0 = 32'h0000_9000; tick(); tick();
    rst = 1; tick(); rst = 0; ren1 = 1; addr1 = 32'h0000_A000;
    settle(); chk("t6_ren0", ren, 0); chk("t6_busy0", busy, 0); advance();
    settle(); chk("t6_first_p0", addr, 32'h0000_9000); advance();
    ren0 = 0; ren1 = 0; tick(); tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) ren0 = ~ren0;
      if ($urandom_range(0, 7) == 0) ren1 = ~ren1;
      addr0   = $urandom;
      addr1   = $urandom;
      data    = $urandom;
      ack     = ($urandom_range(0, 3) == 0);
      suspend = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 127) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mmu_walk_arbiter.md
Name: mmu_walk_arbiter

Overview:
- Shares one page-table fetch port of the memory bus between two MMU walkers: port 0 is instruction-side, port 1 is data-side.
- Each requester presents an unmodified MMU fetch interface (ren/addr/ack/data). The arbiter forwards one requester at a time to the downstream port.
- Grant uses round-robin and is held for a whole walk, so the directory and table fetches stay contiguous.
- A watchdog forces completion when the bus hangs. The forced data word has the present bit clear, so the requesting MMU reports a page fault instead of deadlocking.

Parameters:
- TIMEOUT, 255: cycles without downstream ack (while granted ren is high) before the forced completion fires. Must be at least 1.
- CNT_BITS, 8: watchdog counter width. Must hold TIMEOUT.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- suspend  in  1  abort current walk, same semantics as the MMU suspend
- ren0  in  1  requester 0 read enable, held high for its whole walk
- addr0  in  32  requester 0 fetch address
- ack0  out  1  requester 0 acknowledgement
- data0  out  32  requester 0 read data
- ren1  in  1  requester 1 read enable
- addr1  in  32  requester 1 fetch address
- ack1  out  1  requester 1 acknowledgement
- data1  out  32  requester 1 read data
- ren  out  1  downstream read enable
- addr  out  32  downstream address
- ack  in  1  downstream acknowledgement
- data  in  32  downstream data
- timeout  out  1  one-cycle pulse when the watchdog fires
- busy  out  1  high in S_BUSY or S_DRAIN

Behaviour:
- Reset and suspend:
  - Reset (and any cycle with suspend high): state S_IDLE, grant=0, last=1 (so port 0 wins first), watchdog=0.
  - Forced to zero in that cycle: ren, addr, ack0, ack1, data0, data1, timeout.
  - suspend mid-walk drops downstream ren in the same cycle; a downstream ack arriving that cycle is discarded.
- S_IDLE:
  - Downstream ren=0, addr=0.
  - If exactly one renN is high, grant N and go to S_BUSY.
  - If both are high, grant the port that is not `last`, then go to S_BUSY.
  - One-cycle grant latency: downstream ren rises the cycle after the requester's ren.
- S_BUSY:
  - Combinational pass-through: ren=ren[grant], addr=addr[grant].
  - ack[grant]=ack, data[grant]=data. The ungranted port sees ack=0 and data=0.
  - Watchdog clears on ack or when ren[grant] is low, and increments otherwise.
  - When ren[grant] is sampled low: last<=grant, go to S_IDLE. Any ack arriving that cycle is dropped.
  - Multiple acks per grant are legal; the grant persists across the PDE-to-PTE fetch.
  - When the watchdog reaches TIMEOUT-1 with no ack:
    - In the next cycle, assert ack[grant]=1, data[grant]=0 and timeout=1.
    - Drop downstream ren and go to S_DRAIN.
- S_DRAIN:
  - Downstream ren=0; acks from downstream are ignored.
  - Wait for ren[grant] to go low, then set last<=grant and go to S_IDLE.
  - If the requester re-raises ren with a new walk without ever dropping it, remain in S_DRAIN. The MMU always drops ren after a non-present PDE, so this does not occur in normal operation.
- Simultaneous events:
  - ack together with the watchdog terminal count: ack wins and the watchdog clears.
  - A requester dropping ren in the same cycle as a new request on the other port: release first; the new grant comes next cycle from S_IDLE.
- Fairness: alternating requests are served strictly in turn. Starvation is bounded to one walk plus the timeout.

Decomposition:
- Shared package: state encodings S_IDLE=0, S_BUSY=1, S_DRAIN=2, and the page-entry present bit index (0) used to build the forced fault word.
- Natural sub-module: rr_arb2, a 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Output: grant index and valid.
  - Combinational; reused by the future cache-fill arbiter.
- The watchdog counter stays inline.

Test Plan:
1. Only ren0 rises, addr0=0x0000_1004. Downstream ren=1 and addr=0x0000_1004 one cycle later. Ack with data=0x0000_2003: ack0=1, data0=0x0000_2003, ack1=0.
2. ren0 and ren1 rise together after reset. Port 0 is served first. Once ren0 drops, port 1 is granted next cycle and `last` alternates thereafter.
3. Two-fetch walk on port 1 (PDE then PTE). Grant is held across both acks. A ren0 raised between the fetches is not granted until ren1 falls.
4. TIMEOUT=4, ren0 held, no ack. On the 5th busy cycle: ack0=1, data0=0x0000_0000, timeout=1. The block enters S_DRAIN; after ren0 drops it is back in S_IDLE.
5. suspend pulsed mid-walk while an ack arrives in the same cycle. ren, ack0 and ack1 are all 0 that cycle, and state is S_IDLE next cycle.
6. rst asserted during S_BUSY. All outputs are 0 next cycle. The first grant after reset is port 0 even when both request.
